// File: rtl/multiplicador_seq.sv
// Sequential WIDTH x WIDTH multiplier: one shift-add (unsigned) or radix-2 Booth
// (signed) step per clock, WIDTH cycles per product, registered result and done pulse.
module multiplicador_seq #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_prev;
    logic               r_signed;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [PW-1:0]      r_prod;

    logic               w_mode;
    logic [PW-1:0]      w_mcand_ext;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_acc_next;

    assign w_mode      = Signed & SIGNED_EN;
    assign w_mcand_ext = {{WIDTH{w_mode & Multiplicando[WIDTH-1]}}, Multiplicando};

    // Booth pair (b_i, b_i-1): 01 adds, 10 subtracts the shifted multiplicand.
    always_comb begin
        w_addend = '0;
        if (r_signed) begin
            case ({r_mplier[0], r_prev})
                2'b01:   w_addend = r_mcand;
                2'b10:   w_addend = -r_mcand;
                default: w_addend = '0;
            endcase
        end else if (r_mplier[0]) begin
            w_addend = r_mcand;
        end
        w_acc_next = r_acc + w_addend;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prev   <= 1'b0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_prod   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start && !Abort) begin
                        r_mcand  <= w_mcand_ext;
                        r_mplier <= Multiplicador;
                        r_signed <= w_mode;
                        r_prev   <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (Abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_prev   <= r_mplier[0];
                        r_cnt    <= r_cnt - 1'b1;
                        // Last step: publish the full product straight from the adder.
                        if (r_cnt == CW'(1)) begin
                            r_prod  <= w_acc_next;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Produto = r_prod;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq: a 16-bit signed-capable instance and an
// 8-bit instance with signed mode disabled, all results hand-computed.
module tb_multiplicador_seq;

    logic        Clk;
    logic        Reset_n;
    logic        Start, Abort, Signed;
    logic [15:0] A, B;
    logic        Busy, Done;
    logic [31:0] Produto;

    logic        Start8, Abort8, Signed8;
    logic [7:0]  A8, B8;
    logic        Busy8, Done8;
    logic [15:0] Prod8;

    int n_cmp = 0;
    int n_err = 0;

    multiplicador_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort), .Signed(Signed),
        .Multiplicando(A), .Multiplicador(B), .Busy(Busy), .Done(Done), .Produto(Produto)
    );

    multiplicador_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start8), .Abort(Abort8), .Signed(Signed8),
        .Multiplicando(A8), .Multiplicador(B8), .Busy(Busy8), .Done(Done8), .Produto(Prod8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts an op at the current negedge and returns at the negedge where Done is seen.
    // mode 1: operands/mode scrambled after the start edge; mode 2: stray Start mid-run.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int mode, output int lat, output int busy_n,
                          output logic hold_ok);
        logic [31:0] p0;
        Start = 1'b1; A = a; B = b; Signed = s;
        @(negedge Clk);
        Start = 1'b0;
        if (mode == 1) begin
            A = 16'h0000; B = 16'h0000; Signed = ~s;
        end
        lat = 0; busy_n = 0; hold_ok = 1'b1; p0 = Produto;
        while (!Done && lat < 40) begin
            if (Busy) busy_n++;
            if (Produto !== p0) hold_ok = 1'b0;
            if (mode == 2 && lat == 3) begin
                Start = 1'b1; A = 16'h1111; B = 16'h2222;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [31:0] exp, input int mode);
        int lat, busy_n;
        logic hold_ok;
        run_op(a, b, s, mode, lat, busy_n, hold_ok);
        chk({tag, "_lat"}, 64'(lat), 64'd16);
        chk({tag, "_busy"}, 64'(busy_n), 64'd16);
        chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_prod"}, 64'(Produto), 64'(exp));
    endtask

    task automatic idle_watch(input string tag, input int n);
        int dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        chk(tag, 64'(dones), 64'd0);
    endtask

    initial begin
        int lat8;
        Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Signed = 1'b0; A = '0; B = '0;
        Start8 = 1'b0; Abort8 = 1'b0; Signed8 = 1'b0; A8 = '0; B8 = '0;
        #2;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_prod", 64'(Produto), 64'd0);
        chk("rst_prod8", 64'(Prod8), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // 12 * 75 = 900
        op_check("u12x75", 16'd12, 16'd75, 1'b0, 32'h0000_0384, 0);
        @(negedge Clk);
        chk("done_pulse", 64'(Done), 64'd0);

        // Abort five cycles into RUN: no Done, previous product kept
        Start = 1'b1; A = 16'h00FF; B = 16'h00FF; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_prod", 64'(Produto), 64'h384);
        idle_watch("abort_nodone", 20);
        chk("abort_prod_after", 64'(Produto), 64'h384);

        // Start together with Abort in IDLE is dropped
        Start = 1'b1; Abort = 1'b1; A = 16'd3; B = 16'd3;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        chk("idle_abort_busy", 64'(Busy), 64'd0);
        idle_watch("idle_abort_nodone", 20);

        // 65535^2 = 0xFFFE0001; signed (-1)(-1) = 1; (-32768)^2 = 2^30
        op_check("uffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0);
        @(negedge Clk);
        op_check("sffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0);
        @(negedge Clk);
        op_check("s8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0);
        @(negedge Clk);
        // -3 * 5 = -15; 32767 * -32768 = -0x3FFF8000
        op_check("sneg", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 0);
        @(negedge Clk);
        op_check("smix", 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 0);
        @(negedge Clk);

        // 4001 * 2001 = 8006001 = 0x7A2971; inputs zeroed after the start edge
        op_check("scramble", 16'h0FA1, 16'h07D1, 1'b0, 32'h007A_2971, 1);
        @(negedge Clk);

        // Zero operand still takes the full latency
        op_check("zero", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 0);

        // Back-to-back from the Done cycle; stray Start mid-run is ignored
        op_check("b2b", 16'd100, 16'd200, 1'b0, 32'h0000_4E20, 2);
        idle_watch("stray_nodone", 20);
        chk("stray_prod", 64'(Produto), 64'h4E20);

        // Asynchronous reset between edges mid-run
        Start = 1'b1; A = 16'd7; B = 16'd9; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_done", 64'(Done), 64'd0);
        chk("arst_prod", 64'(Produto), 64'd0);
        #1 Reset_n = 1'b1;
        idle_watch("arst_nodone", 20);
        chk("arst_prod_after", 64'(Produto), 64'd0);
        op_check("post_rst", 16'd12, 16'd75, 1'b0, 32'h0000_0384, 0);

        // WIDTH=8 with signed mode disabled: 255 * 255 = 0xFE01
        Start8 = 1'b1; Signed8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        @(negedge Clk);
        Start8 = 1'b0;
        lat8 = 0;
        while (!Done8 && lat8 < 40) begin
            @(negedge Clk);
            lat8++;
        end
        chk("w8_lat", 64'(lat8), 64'd8);
        chk("w8_prod", 64'(Prod8), 64'hFE01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
